skinny_output_unloader: RTL

Serial ciphertext unloader for the Skinny-128-384 core. The loader side feeds plaintext into the core one byte per cycle while `start` is high. This block is the opposite end of that path. It captures the 128-bit ciphertext when the core raises `done` and streams it out one byte per accepted transfer, most-significant byte first, over a valid/ready handshake. The byte order is the same as the plaintext load order: byte i = bits [127-8i -: 8].

---
 rtl/skinny_output_unloader_if.sv | 23 ++
 rtl/skinny_output_unloader.sv | 99 +++++++++
 2 files changed

// File: rtl/skinny_output_unloader_if.sv
// rtl/skinny_output_unloader_if.sv - byte-stream handshake bundle between the ciphertext unloader and its sink
interface skinny_output_unloader_if #(
    parameter int BYTE_WIDTH = 8
);
    logic [BYTE_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/skinny_output_unloader.sv
// rtl/skinny_output_unloader.sv - captures a Skinny-128-384 ciphertext on core_done rise and streams it MSB byte first
// Optional feature macro: SKINNY_UNLOAD_BACKPRESSURE_EN (defined = out_ready honoured, undefined = one byte per cycle)
module skinny_output_unloader #(
    parameter int BYTE_WIDTH = 8,
    parameter int NUM_BYTES  = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            core_done,
    input  logic [BYTE_WIDTH*NUM_BYTES-1:0] core_ciphertext,
    skinny_output_unloader_if.master        out_if,
    output logic                            busy,
    output logic                            overrun,
    input  logic                            clear_overrun
);
    localparam int BLOCK_W = BYTE_WIDTH * NUM_BYTES;
    localparam int CW      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state_q;
    logic                 done_q;
    logic [BLOCK_W-1:0]   sreg_q;
    logic [CW-1:0]        count_q;
    logic                 overrun_q;

    logic ready_eff;
    logic cap;
    logic send;
    logic accept;
    logic final_beat;

`ifdef SKINNY_UNLOAD_BACKPRESSURE_EN
    assign ready_eff = out_if.out_ready;
`else
    // Sink is assumed always ready; the port stays for pin compatibility.
    logic unused_out_ready;
    assign unused_out_ready = out_if.out_ready;
    assign ready_eff        = 1'b1;
`endif

    assign cap        = core_done & ~done_q;
    assign send       = (state_q == SEND);
    assign accept     = send & ready_eff;
    assign final_beat = accept & (count_q == LAST_IDX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            sreg_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= core_done;

            // A capture landing on the final handshake is a legal back-to-back block, not an overrun.
            if (cap && send && !final_beat) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (cap) begin
                        sreg_q  <= core_ciphertext;
                        count_q <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (count_q != LAST_IDX) begin
                            sreg_q  <= sreg_q << BYTE_WIDTH;
                            count_q <= count_q + 1'b1;
                        end else if (cap) begin
                            sreg_q  <= core_ciphertext;
                            count_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_if.out_data  = sreg_q[BLOCK_W-1 -: BYTE_WIDTH];
    assign out_if.out_valid = send;
    assign out_if.out_last  = send & (count_q == LAST_IDX);
    assign busy             = send;
    assign overrun          = overrun_q;
endmodule
